// File: rtl/coef_mem_responder_if.sv
// Coefficient bus between the neural-net control unit (master) and the
// coefficient memory responder (slave): read/write request plus tagged read data.
interface coef_mem_responder_if #(
    parameter int N = 16,
    parameter int A = 8
);
    logic         e_nd;
    logic [A-1:0] nd_addr;
    logic [7:0]   nd_we;
    logic [N-1:0] din;
    logic [N-1:0] dout;
    logic         rd_valid;
    logic [7:0]   tag_layer;
    logic [7:0]   tag_node;
    logic [7:0]   tag_coef;
    logic         tag_last;

    modport master (
        output e_nd, nd_addr, nd_we, din,
        input  dout, rd_valid, tag_layer, tag_node, tag_coef, tag_last
    );

    modport slave (
        input  e_nd, nd_addr, nd_we, din,
        output dout, rd_valid, tag_layer, tag_node, tag_coef, tag_last
    );
endinterface

// File: rtl/coef_mem_responder.sv
// Coefficient memory responder: 1-cycle write-first reads with (layer,node,coef)
// tagging, bus write-back with save-coverage tracking, and a host preload port.
module coef_mem_responder #(
    parameter int                  N     = 16,
    parameter int                  A     = 8,
    parameter int                  LTOT  = 3,
    parameter logic [32*LTOT-1:0]  LR    = {32'd1, 32'd3, 32'd2},
    parameter int                  DEPTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    coef_mem_responder_if.slave  bus,
    input  logic                 host_we,
    input  logic [A-1:0]         host_addr,
    input  logic [N-1:0]         host_din,
    input  logic                 save_clr,
    output logic [A:0]           save_cnt,
    output logic                 save_done,
    output logic                 err_range,
    output logic                 err_collide,
    output logic                 err_seq
);
    localparam int             IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0]     DEPTH_W   = (A+1)'(DEPTH);
    localparam logic [A-1:0]   LAST_ADDR = A'(DEPTH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, WALK = 1'b1} walk_state_e;

    function automatic logic [7:0] lr_at(input int idx);
        return LR[32*idx +: 8];
    endfunction

    logic [N-1:0]   mem_q [DEPTH];
    logic [N-1:0]   dout_q, rd_word_s;
    logic           rd_valid_q, tag_last_q;
    logic [7:0]     layer_q, layer_d, node_q, node_d, coef_q, coef_d;
    logic [A-1:0]   prev_q, prev_d;
    walk_state_e    state_q, state_d;
    logic [DEPTH-1:0] bitmap_q, bitmap_d;
    logic [A:0]     cnt_q, cnt_d;
    logic           done_q;
    logic           err_range_q, err_range_d, err_collide_q, err_collide_d;
    logic           err_seq_q, err_seq_d;

    logic           in_range_s, host_in_range_s, bus_we_s, host_wr_s, bus_wr_s;
    logic [IW-1:0]  addr_idx_s, host_idx_s;

    assign in_range_s      = {1'b0, bus.nd_addr} < DEPTH_W;
    assign host_in_range_s = {1'b0, host_addr} < DEPTH_W;
    assign bus_we_s        = |bus.nd_we;
    assign host_wr_s       = host_we && host_in_range_s;
    assign bus_wr_s        = bus_we_s && !host_we && in_range_s;
    assign addr_idx_s      = bus.nd_addr[IW-1:0];
    assign host_idx_s      = host_addr[IW-1:0];

    // Read data is write-first: a same-cycle host or bus write is forwarded.
    always_comb begin
        rd_word_s = '0;
        if (!in_range_s) begin
            rd_word_s = '0;
        end else if (host_wr_s && (host_addr == bus.nd_addr)) begin
            rd_word_s = host_din;
        end else if (bus_wr_s) begin
            rd_word_s = bus.din;
        end else begin
            rd_word_s = mem_q[addr_idx_s];
        end
    end

    // Tag walker next state; an out-of-range sequential read ends the walk quietly.
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        node_d    = node_q;
        coef_d    = coef_q;
        prev_d    = prev_q;
        err_seq_d = err_seq_q;
        if (bus.e_nd) begin
            prev_d = bus.nd_addr;
            if (bus.nd_addr == '0) begin
                state_d = WALK;
                layer_d = 8'd1;
                node_d  = 8'd0;
                coef_d  = 8'd0;
            end else if ((state_q == WALK) && (bus.nd_addr == prev_q + A'(1))) begin
                if (!in_range_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WALK;
                    if (coef_q == lr_at(int'(layer_q) - 1)) begin
                        coef_d = 8'd0;
                        if (node_q == lr_at(int'(layer_q)) - 8'd1) begin
                            node_d  = 8'd0;
                            layer_d = layer_q + 8'd1;
                        end else begin
                            node_d = node_q + 8'd1;
                        end
                    end else begin
                        coef_d = coef_q + 8'd1;
                    end
                end
            end else begin
                state_d   = IDLE;
                err_seq_d = 1'b1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Save-coverage bitmap and sticky error flags; a clear beats a coincident write.
    always_comb begin
        bitmap_d      = bitmap_q;
        cnt_d         = cnt_q;
        err_range_d   = err_range_q | ((bus.e_nd | bus_we_s) & ~in_range_s);
        err_collide_d = err_collide_q | (host_we & bus_we_s);
        if (save_clr) begin
            bitmap_d = '0;
            cnt_d    = '0;
        end else if (bus_wr_s && !bitmap_q[addr_idx_s]) begin
            bitmap_d[addr_idx_s] = 1'b1;
            cnt_d                = cnt_q + (A+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output, walker and tracker registers; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q        <= '0;
            rd_valid_q    <= 1'b0;
            tag_last_q    <= 1'b0;
            state_q       <= IDLE;
            layer_q       <= 8'd0;
            node_q        <= 8'd0;
            coef_q        <= 8'd0;
            prev_q        <= '0;
            bitmap_q      <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            err_range_q   <= 1'b0;
            err_collide_q <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            if (bus.e_nd) begin
                dout_q <= rd_word_s;
            end
            rd_valid_q    <= bus.e_nd;
            tag_last_q    <= bus.e_nd && (bus.nd_addr == LAST_ADDR);
            state_q       <= state_d;
            layer_q       <= layer_d;
            node_q        <= node_d;
            coef_q        <= coef_d;
            prev_q        <= prev_d;
            bitmap_q      <= bitmap_d;
            cnt_q         <= cnt_d;
            done_q        <= (cnt_d == DEPTH_W);
            err_range_q   <= err_range_d;
            err_collide_q <= err_collide_d;
            err_seq_q     <= err_seq_d;
        end
    end

    // Coefficient storage; host preload has priority over bus write-back.
    always_ff @(posedge clk) begin
        if (host_wr_s) begin
            mem_q[host_idx_s] <= host_din;
        end else if (bus_wr_s) begin
            mem_q[addr_idx_s] <= bus.din;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.tag_layer = layer_q;
    assign bus.tag_node  = node_q;
    assign bus.tag_coef  = coef_q;
    assign bus.tag_last  = tag_last_q;
    assign save_cnt      = cnt_q;
    assign save_done     = done_q;
    assign err_range     = err_range_q;
    assign err_collide   = err_collide_q;
    assign err_seq       = err_seq_q;
endmodule

// File: tb/tb_coef_mem_responder.sv
// Directed self-checking bench for coef_mem_responder: a read-sweep vector
// table plus hand-written sequences for writes, collisions, errors and reset.
module tb_coef_mem_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       host_we;
    logic [7:0] host_addr;
    logic [15:0] host_din;
    logic       save_clr;
    logic [8:0] save_cnt;
    logic       save_done, err_range, err_collide, err_seq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    coef_mem_responder_if #(.N(16), .A(8)) bus ();

    coef_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .save_clr   (save_clr),
        .save_cnt   (save_cnt),
        .save_done  (save_done),
        .err_range  (err_range),
        .err_collide(err_collide),
        .err_seq    (err_seq)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] exp_dout;
        logic [7:0]  exp_layer;
        logic [7:0]  exp_node;
        logic [7:0]  exp_coef;
        logic        exp_last;
    } rd_vec_t;

    rd_vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.e_nd    = 1'b0;
        bus.nd_addr = 8'd0;
        bus.nd_we   = 8'h00;
        bus.din     = 16'h0000;
        host_we     = 1'b0;
        host_addr   = 8'd0;
        host_din    = 16'h0000;
        save_clr    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        idle_inputs();
        bus.e_nd    = 1'b1;
        bus.nd_addr = a;
        tick();
    endtask

    task automatic chk_tags(input string name, input logic [7:0] l, input logic [7:0] n, input logic [7:0] c);
        chk({name, "_layer"}, bus.tag_layer, l);
        chk({name, "_node"},  bus.tag_node,  n);
        chk({name, "_coef"},  bus.tag_coef,  c);
    endtask

    initial begin
        logic seen [13];
        int   distinct;
        int   order [14];

        vecs[0]  = '{8'd0,  16'd100, 8'd1, 8'd0, 8'd0, 1'b0};
        vecs[1]  = '{8'd1,  16'd101, 8'd1, 8'd0, 8'd1, 1'b0};
        vecs[2]  = '{8'd2,  16'd102, 8'd1, 8'd0, 8'd2, 1'b0};
        vecs[3]  = '{8'd3,  16'd103, 8'd1, 8'd1, 8'd0, 1'b0};
        vecs[4]  = '{8'd4,  16'd104, 8'd1, 8'd1, 8'd1, 1'b0};
        vecs[5]  = '{8'd5,  16'd105, 8'd1, 8'd1, 8'd2, 1'b0};
        vecs[6]  = '{8'd6,  16'd106, 8'd1, 8'd2, 8'd0, 1'b0};
        vecs[7]  = '{8'd7,  16'd107, 8'd1, 8'd2, 8'd1, 1'b0};
        vecs[8]  = '{8'd8,  16'd108, 8'd1, 8'd2, 8'd2, 1'b0};
        vecs[9]  = '{8'd9,  16'd109, 8'd2, 8'd0, 8'd0, 1'b0};
        vecs[10] = '{8'd10, 16'd110, 8'd2, 8'd0, 8'd1, 1'b0};
        vecs[11] = '{8'd11, 16'd111, 8'd2, 8'd0, 8'd2, 1'b0};
        vecs[12] = '{8'd12, 16'd112, 8'd2, 8'd0, 8'd3, 1'b1};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_valid", bus.rd_valid, 32'd0);
        chk_tags("rst", 8'd0, 8'd0, 8'd0);
        chk("rst_cnt", save_cnt, 32'd0);
        chk("rst_errs", {err_range, err_collide, err_seq, save_done}, 32'd0);
        rst = 1'b0;

        // Host preload mem[k] = k + 100
        for (int k = 0; k < 13; k++) begin
            idle_inputs();
            host_we   = 1'b1;
            host_addr = 8'(k);
            host_din  = 16'(k + 100);
            tick();
        end
        idle_inputs();
        tick();
        chk("preload_cnt", save_cnt, 32'd0);

        // Sequential read sweep
        for (int i = 0; i < 13; i++) begin
            rd(vecs[i].addr);
            chk($sformatf("sweep%0d_dout", i), bus.dout, vecs[i].exp_dout);
            chk($sformatf("sweep%0d_valid", i), bus.rd_valid, 32'd1);
            chk_tags($sformatf("sweep%0d", i), vecs[i].exp_layer, vecs[i].exp_node, vecs[i].exp_coef);
            chk($sformatf("sweep%0d_last", i), bus.tag_last, vecs[i].exp_last);
        end
        idle_inputs();
        tick();
        chk("hold_valid", bus.rd_valid, 32'd0);
        chk("hold_dout", bus.dout, 32'd112);
        chk("hold_last", bus.tag_last, 32'd0);
        chk("sweep_err_seq", err_seq, 32'd0);
        chk("sweep_err_range", err_range, 32'd0);

        // Sequential read past the end
        rd(8'd13);
        chk("past_dout", bus.dout, 32'd0);
        chk("past_valid", bus.rd_valid, 32'd1);
        chk("past_err_range", err_range, 32'd1);
        chk("past_err_seq", err_seq, 32'd0);
        chk_tags("past", 8'd2, 8'd0, 8'd3);

        // Non-sequential read 0,1,3
        rd(8'd0);
        rd(8'd1);
        chk("seq_pre_err", err_seq, 32'd0);
        rd(8'd3);
        chk("seq_err", err_seq, 32'd1);
        chk("seq_dout", bus.dout, 32'd103);
        chk_tags("seq_hold", 8'd1, 8'd0, 8'd1);

        // Save tracker: writes 0..12 with address 5 twice
        for (int k = 0; k < 13; k++) seen[k] = 1'b0;
        distinct = 0;
        for (int k = 0; k < 6; k++) order[k] = k;
        order[6] = 5;
        for (int k = 6; k < 13; k++) order[k + 1] = k;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            bus.nd_we   = 8'hFF;
            bus.nd_addr = 8'(order[i]);
            bus.din     = 16'(16'h0200 + order[i]);
            tick();
            if (!seen[order[i]]) begin
                seen[order[i]] = 1'b1;
                distinct++;
            end
            chk($sformatf("save%0d_cnt", i), save_cnt, distinct);
            chk($sformatf("save%0d_done", i), save_done, (distinct == 13) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        save_clr = 1'b1;
        tick();
        chk("clr_cnt", save_cnt, 32'd0);
        chk("clr_done", save_done, 32'd0);

        // Same-cycle read and write at address 4
        idle_inputs();
        bus.e_nd    = 1'b1;
        bus.nd_we   = 8'hFF;
        bus.nd_addr = 8'd4;
        bus.din     = 16'h0ABC;
        tick();
        chk("wf_dout", bus.dout, 32'h0ABC);
        chk("wf_cnt", save_cnt, 32'd1);
        rd(8'd4);
        chk("wf_reread", bus.dout, 32'h0ABC);

        // Host and bus write collide at address 3, with a read of 3
        idle_inputs();
        host_we     = 1'b1;
        host_addr   = 8'd3;
        host_din    = 16'h1111;
        bus.e_nd    = 1'b1;
        bus.nd_we   = 8'hFF;
        bus.nd_addr = 8'd3;
        bus.din     = 16'h2222;
        tick();
        chk("col_dout", bus.dout, 32'h1111);
        chk("col_err", err_collide, 32'd1);
        chk("col_cnt", save_cnt, 32'd1);
        rd(8'd3);
        chk("col_reread", bus.dout, 32'h1111);

        // Reset coinciding with a read of address 2
        idle_inputs();
        rst         = 1'b1;
        bus.e_nd    = 1'b1;
        bus.nd_addr = 8'd2;
        tick();
        rst = 1'b0;
        chk("rrd_valid", bus.rd_valid, 32'd0);
        chk("rrd_dout", bus.dout, 32'd0);
        chk("rrd_flags", {err_range, err_collide, err_seq, save_done}, 32'd0);
        chk("rrd_cnt", save_cnt, 32'd0);
        chk_tags("rrd", 8'd0, 8'd0, 8'd0);
        rd(8'd2);
        chk("post_rst_dout", bus.dout, 32'h0202);
        chk("post_rst_valid", bus.rd_valid, 32'd1);

        // Out-of-range read and write
        rd(8'd20);
        chk("oor_dout", bus.dout, 32'd0);
        chk("oor_valid", bus.rd_valid, 32'd1);
        chk("oor_err", err_range, 32'd1);
        idle_inputs();
        bus.nd_we   = 8'hFF;
        bus.nd_addr = 8'd20;
        bus.din     = 16'h5A5A;
        tick();
        chk("oor_wr_cnt", save_cnt, 32'd0);
        rd(8'd4);
        chk("oor_wr_mem4", bus.dout, 32'h0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coef_mem_responder.md
Name: coef_mem_responder

Overview:
- Memory-side responder on the coefficient bus (nd_addr / e_nd / nd_we) that the neural-net control unit drives.
- Serves coefficient reads with a fixed 1-cycle latency and accepts write-back of trained coefficients.
- Tags each returned word with its (layer, node, coef) position and tracks save completeness.
- Also provides a host preload port for initial weights.

Parameters:
N, 16, word width (equals `n from fixed_point.vh)
A, 8, address width
LTOT, 3, number of layers including the input layer
LR, {32'd1,32'd3,32'd2}, packed layer sizes, 32 bits each; LR[0+:32]=inputs
DEPTH, 13, total words = sum over l=1..LTOT-1 of LR[l]*(LR[l-1]+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
e_nd  in  1  bus read enable
nd_addr  in  A  bus address
nd_we  in  8  bus write enable; any bit set writes the whole word
din  in  N  bus write data
host_we  in  1  host preload write
host_addr  in  A  host address
host_din  in  N  host data
save_clr  in  1  clear the write-coverage tracker
dout  out  N  read data
rd_valid  out  1  dout valid (1-cycle pulse per read)
tag_layer  out  8  layer of dout (1..LTOT-1)
tag_node  out  8  node index within the layer
tag_coef  out  8  coef index; 0..LR[l-1]-1 are weights, LR[l-1] is the bias
tag_last  out  1  dout is address DEPTH-1
save_cnt  out  A+1  distinct addresses written since clear
save_done  out  1  all DEPTH addresses written since clear (level)
err_range  out  1  sticky: access with address >= DEPTH
err_collide  out  1  sticky: bus write dropped because host_we was active
err_seq  out  1  sticky: non-sequential read, tags invalid

Behaviour:
- Reset (sync, rst high at posedge):
  - All outputs go to 0; save bitmap cleared; walker goes to IDLE.
  - Memory contents are preserved.
  - A read issued in the reset cycle is dropped: rd_valid is 0 in the following cycle.
- Read:
  - e_nd=1 at cycle t with addr → dout=mem[addr] and rd_valid=1 at t+1.
  - Otherwise rd_valid=0 and dout holds its last value.
  - Reads are continuous: one per cycle, no stall.
- Write:
  - Occurs when |nd_we and host_we=0; mem[nd_addr]<=din at the end of the cycle.
  - When read and write hit the same address in the same cycle, the read is write-first and returns din.
- Host write:
  - host_we has priority over a bus write. A simultaneous bus write is dropped and err_collide is set.
  - A host write does not mark the save bitmap.
  - Host write together with a bus read to the same address: the read is also write-first and returns host_din.
- Out of range (addr >= DEPTH):
  - A read returns dout=0 with rd_valid=1.
  - A write is ignored.
  - err_range is set in both cases.
- Save tracker:
  - Each accepted in-range bus write sets bitmap[addr]; save_cnt increments only on first set.
  - save_done = (save_cnt == DEPTH).
  - save_clr zeroes bitmap and save_cnt next cycle. If save_clr coincides with a write, the clear wins.
- Tag walker: states IDLE, WALK; registered with dout, same timing.
  - Read at addr 0, from any state → tags (1,0,0), state WALK.
  - Read in WALK with addr == prev_addr+1:
    - if coef == LR[layer-1] → coef=0 and node+1;
    - if that node was LR[layer]-1 → node=0 and layer+1;
    - otherwise coef+1.
  - Any other read address (IDLE non-zero, or WALK non-sequential): tags hold, err_seq set, state IDLE.
  - Address DEPTH-1 asserts tag_last with rd_valid. The next sequential read is out of range: err_range set, state IDLE.
- Sticky error flags clear only on rst.
- Widths: the address compare uses A bits zero-extended; save_cnt is A+1 bits so that it can hold DEPTH.

Test Plan:
- Host preload mem[k]=k+100 for k=0..12, then e_nd with nd_addr 0..12 one per cycle → dout 100..112, each 1 cycle after its address. Tags run (1,0,0),(1,0,1),(1,0,2),(1,1,0)…(1,2,2),(2,0,0)…(2,0,3); tag_last only on addr 12.
- Bus writes nd_we=8'hFF to addr 0..12, with addr 5 written twice → save_cnt=13 and save_done=1 after the 13th distinct write. Pulse save_clr → save_cnt=0 and save_done=0 the next cycle.
- Same-cycle read+write at addr 4 with din=16'h0ABC → dout=0ABC next cycle. Read addr 4 again → 0ABC.
- host_we and bus write together at addr 3 (host 16'h1111, bus 16'h2222) → mem[3]=1111, err_collide=1, save_cnt unchanged.
- Read addr 20 → dout=0, rd_valid=1, err_range=1. Write addr 20 → memory unchanged. Read sequence 0,1,3 → err_seq=1 and tags hold at (1,0,1).
- Assert rst in the same cycle as a read of addr 2 → rd_valid=0 next cycle, all flags and tags 0. A subsequent read of addr 2 returns the pre-reset contents.
